roce_latency_run_ctrl: RTL and testbench
========================================

# roce_latency_run_ctrl

Sequencer for RoCE write-latency measurement runs. It arms the latency evaluator, issues a configured number of RDMA WRITE work requests one at a time to the TX request path, and waits for each message's ACK before the next is issued. For each message it samples the evaluator's last-packet latency and accumulates min/max/sum statistics, with a per-message ACK timeout. It sits between the control/status register file and the RoCE TX request interface, alongside the latency evaluator.

## Interface
- LAT_WIDTH, 64, latency sample and statistic width
- CNT_WIDTH, 32, message counter width
- TIMEOUT_CYCLES, 1048576, maximum cycles from request accept to ACK
- clk  in  1  clock
- rst  in  1  reset; rst, synchronous, active-high; clock clk
- cfg_start  in  1  pulse; starts a run when idle
- cfg_abort  in  1  pulse; aborts the run in progress
- cfg_num_msgs  in  CNT_WIDTH  messages per run; sampled at start
- cfg_msg_length  in  32  bytes per message; sampled at start
- cfg_base_addr  in  64  remote virtual address of the first message; sampled at start
- cfg_gap  in  16  idle cycles between an ACK and the next request; sampled at start
- eval_start_o  out  1  drives the evaluator's start_i; its rising edge clears the evaluator
- m_req_valid / m_req_ready  out/in  1  write-request handshake
- m_req_addr  out  64  remote virtual address of the current message
- m_req_length  out  32  length of the current message
- s_ack_valid  in  1  one-cycle pulse when the last-PSN ACK of the current message is received
- s_lat_last  in  LAT_WIDTH  evaluator latency_last_packet
- busy, done, timeout_err  out  1  status
- msgs_done  out  CNT_WIDTH  completed messages
- lat_min, lat_max, lat_sum  out  LAT_WIDTH  statistics

## Operation
- States: IDLE, ARM, ISSUE, WAIT_ACK, SAMPLE, GAP, DONE.
- IDLE:
  - On cfg_start, latch all cfg_*.
  - Clear msgs_done, lat_max, lat_sum and timeout_err; set lat_min to all-ones.
  - Clear done and go to ARM.
- ARM: eval_start_o is 0 in this state, which guarantees a rising edge. Next cycle go to ISSUE with eval_start_o=1.
  - eval_start_o stays 1 until the run leaves for DONE or IDLE.
- If the latched num_msgs==0: ARM goes directly to DONE. No request is issued and lat_min stays all-ones.
- ISSUE:
  - Drive m_req_valid=1 and hold addr/length stable until ready.
  - On valid&ready, go to WAIT_ACK and load the timeout counter with 0.
- WAIT_ACK:
  - The counter increments each cycle.
  - s_ack_valid: go to SAMPLE.
  - Counter reaching TIMEOUT_CYCLES-1 without an ACK: set timeout_err and go to DONE.
- SAMPLE (exactly one cycle, because the evaluator registers its latency one cycle after the ACK):
  - Capture s_lat_last and update min, max and sum.
  - Sum saturates at all-ones.
  - msgs_done += 1.
  - Advance addr: addr += length, modulo 2^64.
  - If msgs_done (new value) == num_msgs, go to DONE. Else, if gap==0, go to ISSUE; otherwise go to GAP.
- GAP: count gap cycles, then go to ISSUE.
- DONE:
  - done=1 and eval_start_o=0; statistics are held.
  - cfg_start starts a new run (same behaviour as from IDLE).
- cfg_abort in any non-IDLE state:
  - Go to IDLE next cycle; eval_start_o=0, m_req_valid=0, done stays 0.
  - Statistics are held.
  - An abort in ISSUE withdraws valid without a handshake. This is permitted on this interface only by abort.
- cfg_start while busy is ignored.
- cfg_start and cfg_abort in the same cycle: abort wins.
- s_ack_valid outside WAIT_ACK is ignored.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, except lat_min = all-ones.
- Request issue latency:
  - From cfg_start to the first m_req_valid: 2 cycles (IDLE→ARM→ISSUE).
  - From ACK to the next m_req_valid: 2 + gap cycles.
- busy=1 in all states except IDLE and DONE.
- Statistic outputs update in the cycle after SAMPLE.
- done rises the cycle after the final SAMPLE or the timeout.

## Structure
- Shared package: FSM state encoding localparams.
- Shared package: the RC opcode constants already used by the latency evaluator (WRITE_FIRST 0x06 … ACK 0x11). This block does not decode opcodes, but the package keeps them common.
- Optional sub-module: roce_lat_stats, holding the min/max/saturating-sum accumulator with clear and update strobes.
- Everything else is flat in this module.

## Test plan
- num_msgs=3, length=4096, base=0x1000, gap=0, ready always 1, ACKs 50 cycles after each accept, s_lat_last = 100, 80, 120 → three requests at addr 0x1000, 0x2000, 0x3000; min=80, max=120, sum=300; msgs_done=3; done=1; timeout_err=0.
- num_msgs=0 → no m_req_valid; done 2 cycles after cfg_start; eval_start_o pulses high for 0 cycles; lat_min all-ones.
- Tiny TIMEOUT_CYCLES=16, no ACK → timeout_err=1 and done=1 exactly 16 cycles after the accept; msgs_done=0.
- m_req_ready held low 10 cycles with gap=5 → addr/length stable while stalled; second valid appears exactly 7 cycles after the first ACK.
- cfg_abort mid-WAIT_ACK, then a spurious s_ack_valid → state IDLE; eval_start_o=0; statistics unchanged; a new cfg_start rearms with a fresh eval_start_o rising edge.
- base=0xFFFF_FFFF_FFFF_F000, length=0x1000, num_msgs=2 → second addr=0; lat sum saturation checked with s_lat_last = all-ones twice → sum = all-ones.

Source files
------------

// File: rtl/roce_latency_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : roce_latency_run_ctrl_pkg
// Brief    : Shared state encoding and RC opcode constants for the RoCE
//            latency measurement blocks.
// Revision : 1.0 - initial release
// ============================================================================
package roce_latency_run_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE     = 3'd0;
    localparam state_t c_ST_ARM      = 3'd1;
    localparam state_t c_ST_ISSUE    = 3'd2;
    localparam state_t c_ST_WAIT_ACK = 3'd3;
    localparam state_t c_ST_SAMPLE   = 3'd4;
    localparam state_t c_ST_GAP      = 3'd5;
    localparam state_t c_ST_DONE     = 3'd6;

    // Same opcode values the latency evaluator decodes
    typedef enum logic [7:0] {
        c_RC_WRITE_FIRST     = 8'h06,
        c_RC_WRITE_MIDDLE    = 8'h07,
        c_RC_WRITE_LAST      = 8'h08,
        c_RC_WRITE_LAST_IMM  = 8'h09,
        c_RC_WRITE_ONLY      = 8'h0A,
        c_RC_WRITE_ONLY_IMM  = 8'h0B,
        c_RC_READ_REQUEST    = 8'h0C,
        c_RC_READ_RESP_FIRST = 8'h0D,
        c_RC_READ_RESP_MID   = 8'h0E,
        c_RC_READ_RESP_LAST  = 8'h0F,
        c_RC_READ_RESP_ONLY  = 8'h10,
        c_RC_ACK             = 8'h11
    } rc_opcode_e;

endpackage
`default_nettype wire

// File: rtl/roce_lat_stats.sv
`default_nettype none
// ============================================================================
// Module   : roce_lat_stats
// Brief    : Min / max / saturating-sum latency accumulator with clear and
//            update strobes.
// Revision : 1.0 - initial release
// ============================================================================
module roce_lat_stats #(
    parameter int LAT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 upd,
    input  logic [LAT_WIDTH-1:0] sample,
    output logic [LAT_WIDTH-1:0] lat_min,
    output logic [LAT_WIDTH-1:0] lat_max,
    output logic [LAT_WIDTH-1:0] lat_sum
);

    logic [LAT_WIDTH:0] w_sum_ext;

    assign w_sum_ext = {1'b0, lat_sum} + {1'b0, sample};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lat_min <= '1;
            lat_max <= '0;
            lat_sum <= '0;
        end else if (upd) begin
            if (sample < lat_min) lat_min <= sample;
            if (sample > lat_max) lat_max <= sample;
            lat_sum <= w_sum_ext[LAT_WIDTH] ? '1 : w_sum_ext[LAT_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/roce_latency_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : roce_latency_run_ctrl
// Brief    : Sequences a RoCE write-latency run: arms the evaluator, issues
//            one WRITE at a time, waits for its ACK and accumulates stats.
// Revision : 1.0 - initial release
// ============================================================================
module roce_latency_run_ctrl
    import roce_latency_run_ctrl_pkg::*;
#(
    parameter int LAT_WIDTH      = 64,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic [CNT_WIDTH-1:0] cfg_num_msgs,
    input  logic [31:0]          cfg_msg_length,
    input  logic [63:0]          cfg_base_addr,
    input  logic [15:0]          cfg_gap,
    output logic                 eval_start_o,
    output logic                 m_req_valid,
    input  logic                 m_req_ready,
    output logic [63:0]          m_req_addr,
    output logic [31:0]          m_req_length,
    input  logic                 s_ack_valid,
    input  logic [LAT_WIDTH-1:0] s_lat_last,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] msgs_done,
    output logic [LAT_WIDTH-1:0] lat_min,
    output logic [LAT_WIDTH-1:0] lat_max,
    output logic [LAT_WIDTH-1:0] lat_sum
);

    localparam int                TMO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_num_msgs;
    logic [31:0]          r_len;
    logic [63:0]          r_addr;
    logic [15:0]          r_gap;
    logic [15:0]          r_gap_cnt;
    logic [TMO_W-1:0]     r_tmo_cnt;
    logic [TMO_W-1:0]     w_tmo_nxt;
    logic [CNT_WIDTH-1:0] r_msgs_done;
    logic [CNT_WIDTH-1:0] w_msgs_inc;
    logic                 r_timeout_err;
    logic                 w_run_start;
    logic                 w_tmo_hit;
    logic                 w_sample;

    assign w_tmo_nxt  = r_tmo_cnt + 1'b1;
    assign w_msgs_inc = r_msgs_done + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_start = 1'b0;
        w_tmo_hit   = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (cfg_start) begin
                    w_run_start = 1'b1;
                    w_state_nxt = c_ST_ARM;
                end
            end
            c_ST_ARM:
                w_state_nxt = (r_num_msgs == '0) ? c_ST_DONE : c_ST_ISSUE;
            c_ST_ISSUE: begin
                if (m_req_ready) w_state_nxt = c_ST_WAIT_ACK;
            end
            c_ST_WAIT_ACK: begin
                // An ACK arriving on the last allowed cycle still counts
                if (s_ack_valid) begin
                    w_state_nxt = c_ST_SAMPLE;
                end else if (w_tmo_nxt == c_TMO_LAST) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_SAMPLE: begin
                w_sample = 1'b1;
                if (w_msgs_inc == r_num_msgs) w_state_nxt = c_ST_DONE;
                else if (r_gap == '0)         w_state_nxt = c_ST_ISSUE;
                else                          w_state_nxt = c_ST_GAP;
            end
            c_ST_GAP: begin
                if (r_gap_cnt <= 16'd1) w_state_nxt = c_ST_ISSUE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        // Abort dominates every other event, including a coincident start
        if (cfg_abort) begin
            w_state_nxt = c_ST_IDLE;
            w_run_start = 1'b0;
            w_tmo_hit   = 1'b0;
            w_sample    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_msgs    <= '0;
            r_len         <= '0;
            r_addr        <= '0;
            r_gap         <= '0;
            r_gap_cnt     <= '0;
            r_tmo_cnt     <= '0;
            r_msgs_done   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_run_start) begin
                r_num_msgs    <= cfg_num_msgs;
                r_len         <= cfg_msg_length;
                r_addr        <= cfg_base_addr;
                r_gap         <= cfg_gap;
                r_msgs_done   <= '0;
                r_timeout_err <= 1'b0;
            end
            if (r_state == c_ST_ISSUE)         r_tmo_cnt <= '0;
            else if (r_state == c_ST_WAIT_ACK) r_tmo_cnt <= w_tmo_nxt;
            if (w_tmo_hit) r_timeout_err <= 1'b1;
            if (w_sample) begin
                r_msgs_done <= w_msgs_inc;
                r_addr      <= r_addr + {32'd0, r_len};
                r_gap_cnt   <= r_gap;
            end else if (r_state == c_ST_GAP) begin
                r_gap_cnt <= r_gap_cnt - 16'd1;
            end
        end
    end

    roce_lat_stats #(
        .LAT_WIDTH (LAT_WIDTH)
    ) u_stats (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_run_start),
        .upd     (w_sample),
        .sample  (s_lat_last),
        .lat_min (lat_min),
        .lat_max (lat_max),
        .lat_sum (lat_sum)
    );

    assign eval_start_o = (r_state == c_ST_ISSUE) || (r_state == c_ST_WAIT_ACK) ||
                          (r_state == c_ST_SAMPLE) || (r_state == c_ST_GAP);
    assign m_req_valid  = (r_state == c_ST_ISSUE);
    assign m_req_addr   = r_addr;
    assign m_req_length = r_len;
    assign busy         = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
    assign done         = (r_state == c_ST_DONE);
    assign timeout_err  = r_timeout_err;
    assign msgs_done    = r_msgs_done;

endmodule
`default_nettype wire

// File: tb/tb_roce_latency_run_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_roce_latency_run_ctrl
// Brief    : Scoreboard bench for roce_latency_run_ctrl (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_roce_latency_run_ctrl;

    localparam int LW = 64;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0, cfg_start2 = 1'b0, cfg_abort = 1'b0;
    logic [CW-1:0] cfg_num_msgs = '0;
    logic [31:0]   cfg_msg_length = '0;
    logic [63:0]   cfg_base_addr = '0;
    logic [15:0]   cfg_gap = '0;
    logic          m_req_ready = 1'b0;
    logic          s_ack_valid = 1'b0;
    logic [LW-1:0] s_lat_last = '0;

    logic          eval_start, m_req_valid, busy, done, timeout_err;
    logic [63:0]   m_req_addr;
    logic [31:0]   m_req_length;
    logic [CW-1:0] msgs_done;
    logic [LW-1:0] lat_min, lat_max, lat_sum;

    logic          eval_start_t, m_req_valid_t, busy_t, done_t, timeout_err_t;
    logic [63:0]   m_req_addr_t;
    logic [31:0]   m_req_length_t;
    logic [CW-1:0] msgs_done_t;
    logic [LW-1:0] lat_min_t, lat_max_t, lat_sum_t;

    always #5 clk = ~clk;

    roce_latency_run_ctrl dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_num_msgs(cfg_num_msgs), .cfg_msg_length(cfg_msg_length),
        .cfg_base_addr(cfg_base_addr), .cfg_gap(cfg_gap),
        .eval_start_o(eval_start), .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_addr(m_req_addr), .m_req_length(m_req_length),
        .s_ack_valid(s_ack_valid), .s_lat_last(s_lat_last),
        .busy(busy), .done(done), .timeout_err(timeout_err), .msgs_done(msgs_done),
        .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum)
    );

    roce_latency_run_ctrl #(.TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .rst(rst), .cfg_start(cfg_start2), .cfg_abort(cfg_abort),
        .cfg_num_msgs(cfg_num_msgs), .cfg_msg_length(cfg_msg_length),
        .cfg_base_addr(cfg_base_addr), .cfg_gap(cfg_gap),
        .eval_start_o(eval_start_t), .m_req_valid(m_req_valid_t), .m_req_ready(m_req_ready),
        .m_req_addr(m_req_addr_t), .m_req_length(m_req_length_t),
        .s_ack_valid(s_ack_valid), .s_lat_last(s_lat_last),
        .busy(busy_t), .done(done_t), .timeout_err(timeout_err_t), .msgs_done(msgs_done_t),
        .lat_min(lat_min_t), .lat_max(lat_max_t), .lat_sum(lat_sum_t)
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
    } req_t;

    typedef struct {
        logic [CW-1:0] msgs;
        logic [LW-1:0] mn;
        logic [LW-1:0] mx;
        logic [LW-1:0] sm;
        logic          te;
    } res_t;

    req_t exp_req[$];
    res_t exp_res[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    localparam logic [63:0] ONES = '1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired, expected event never seen", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [63:0] a, input logic [31:0] l);
        req_t r;
        r.addr = a;
        r.len  = l;
        exp_req.push_back(r);
    endtask

    task automatic push_res(input logic [CW-1:0] n, input logic [LW-1:0] mn,
                            input logic [LW-1:0] mx, input logic [LW-1:0] sm, input logic te);
        res_t e;
        e.msgs = n; e.mn = mn; e.mx = mx; e.sm = sm; e.te = te;
        exp_res.push_back(e);
    endtask

    task automatic config_run(input logic [CW-1:0] n, input logic [31:0] l,
                              input logic [63:0] b, input logic [15:0] g);
        cfg_num_msgs = n; cfg_msg_length = l; cfg_base_addr = b; cfg_gap = g;
    endtask

    // Leaves the caller one cycle after the cycle cfg_start was high
    task automatic start_run();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_accept(input int budget, input string name);
        int k = 0;
        while (!(m_req_valid && m_req_ready) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) expire(name);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) expire(name);
    endtask

    // Waits for the handshake, then drives the ACK `delay` cycles after it
    task automatic serve_msg(input int delay, input logic [LW-1:0] lat, input string name);
        wait_accept(200, name);
        repeat (delay) tick();
        s_ack_valid = 1'b1;
        s_lat_last  = lat;
        tick();
        s_ack_valid = 1'b0;
    endtask

    // Scoreboard monitor: requests and completion results
    initial begin : monitor
        req_t r;
        res_t e;
        logic done_q;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_req_valid && m_req_ready) begin
                    if (exp_req.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_req: got addr 0x%0h, expected no request", m_req_addr);
                    end else begin
                        r = exp_req.pop_front();
                        chk("req_addr", m_req_addr, r.addr);
                        chk("req_len", 64'(m_req_length), 64'(r.len));
                    end
                end
                if (done && !done_q) begin
                    if (exp_res.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1, expected no completion");
                    end else begin
                        e = exp_res.pop_front();
                        chk("res_msgs_done", 64'(msgs_done), 64'(e.msgs));
                        chk("res_lat_min", lat_min, e.mn);
                        chk("res_lat_max", lat_max, e.mx);
                        chk("res_lat_sum", lat_sum, e.sm);
                        chk("res_timeout_err", 64'(timeout_err), 64'(e.te));
                    end
                end
                done_q = done;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [63:0] a0;
        logic [31:0] l0;
        logic        stable;

        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(m_req_valid), 64'd0);
        chk("rst_eval", 64'(eval_start), 64'd0);
        chk("rst_lat_min", lat_min, ONES);
        chk("rst_lat_max", lat_max, 64'd0);
        chk("rst_lat_sum", lat_sum, 64'd0);
        chk("rst_msgs", 64'(msgs_done), 64'd0);
        chk("rst_addr", m_req_addr, 64'd0);
        tick();

        // Three messages, gap 0, latencies 100/80/120
        m_req_ready = 1'b1;
        config_run(32'd3, 32'd4096, 64'h1000, 16'd0);
        push_req(64'h1000, 32'd4096);
        push_req(64'h2000, 32'd4096);
        push_req(64'h3000, 32'd4096);
        push_res(32'd3, 64'd80, 64'd120, 64'd300, 1'b0);
        start_run();
        chk("t1_valid_c1", 64'(m_req_valid), 64'd0);
        chk("t1_busy_c1", 64'(busy), 64'd1);
        tick();
        chk("t1_valid_c2", 64'(m_req_valid), 64'd1);
        chk("t1_eval_c2", 64'(eval_start), 64'd1);
        serve_msg(50, 64'd100, "t1_msg0");
        serve_msg(50, 64'd80, "t1_msg1");
        serve_msg(50, 64'd120, "t1_msg2");
        tick();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_eval_end", 64'(eval_start), 64'd0);
        repeat (3) tick();

        // Zero-message run
        config_run(32'd0, 32'd64, 64'h4000, 16'd0);
        push_res(32'd0, ONES, 64'd0, 64'd0, 1'b0);
        start_run();
        chk("t2_done_c1", 64'(done), 64'd0);
        chk("t2_eval_c1", 64'(eval_start), 64'd0);
        tick();
        chk("t2_done_c2", 64'(done), 64'd1);
        chk("t2_eval_c2", 64'(eval_start), 64'd0);
        chk("t2_lat_min", lat_min, ONES);
        repeat (3) tick();

        // Timeout on the TIMEOUT_CYCLES=16 instance, no ACK ever
        config_run(32'd1, 32'd256, 64'h8000, 16'd0);
        cfg_start2 = 1'b1;
        tick();
        cfg_start2 = 1'b0;
        begin
            int k = 0;
            while (!(m_req_valid_t && m_req_ready) && k < 20) begin
                tick();
                k++;
            end
            if (k >= 20) expire("t3_accept");
        end
        repeat (15) tick();
        chk("t3_done_c15", 64'(done_t), 64'd0);
        tick();
        chk("t3_done_c16", 64'(done_t), 64'd1);
        chk("t3_timeout_err", 64'(timeout_err_t), 64'd1);
        chk("t3_msgs_done", 64'(msgs_done_t), 64'd0);
        chk("t3_busy", 64'(busy_t), 64'd0);
        repeat (2) tick();

        // Stalled ready plus gap=5
        m_req_ready = 1'b0;
        config_run(32'd2, 32'h200, 64'h5000, 16'd5);
        push_req(64'h5000, 32'h200);
        push_req(64'h5200, 32'h200);
        push_res(32'd2, 64'd7, 64'd9, 64'd16, 1'b0);
        start_run();
        tick();
        a0     = m_req_addr;
        l0     = m_req_length;
        stable = m_req_valid;
        repeat (10) begin
            tick();
            if (!m_req_valid || m_req_addr !== a0 || m_req_length !== l0) stable = 1'b0;
        end
        chk("t4_stall_stable", 64'(stable), 64'd1);
        m_req_ready = 1'b1;
        serve_msg(3, 64'd9, "t4_msg0");
        repeat (5) tick();
        chk("t4_valid_ack6", 64'(m_req_valid), 64'd0);
        tick();
        chk("t4_valid_ack7", 64'(m_req_valid), 64'd1);
        serve_msg(3, 64'd7, "t4_msg1");
        wait_done(20, "t4_done");
        repeat (3) tick();

        // Abort mid-WAIT_ACK, spurious ACK, then rearm
        config_run(32'd3, 32'h100, 64'h9000, 16'd0);
        push_req(64'h9000, 32'h100);
        start_run();
        wait_accept(20, "t5_accept");
        repeat (5) tick();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        s_ack_valid = 1'b1;
        s_lat_last  = 64'd5;
        tick();
        s_ack_valid = 1'b0;
        tick();
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_eval", 64'(eval_start), 64'd0);
        chk("t5_valid", 64'(m_req_valid), 64'd0);
        chk("t5_msgs", 64'(msgs_done), 64'd0);
        chk("t5_lat_min", lat_min, ONES);
        chk("t5_lat_sum", lat_sum, 64'd0);
        m_req_ready = 1'b0;
        start_run();
        chk("t5_rearm_eval_c1", 64'(eval_start), 64'd0);
        tick();
        chk("t5_rearm_eval_c2", 64'(eval_start), 64'd1);
        chk("t5_rearm_valid", 64'(m_req_valid), 64'd1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("t5_withdraw_valid", 64'(m_req_valid), 64'd0);
        chk("t5_withdraw_eval", 64'(eval_start), 64'd0);
        chk("t5_withdraw_done", 64'(done), 64'd0);
        repeat (2) tick();

        // Address wrap and saturating sum
        m_req_ready = 1'b1;
        config_run(32'd2, 32'h1000, 64'hFFFF_FFFF_FFFF_F000, 16'd0);
        push_req(64'hFFFF_FFFF_FFFF_F000, 32'h1000);
        push_req(64'h0, 32'h1000);
        push_res(32'd2, ONES, ONES, ONES, 1'b0);
        start_run();
        serve_msg(4, ONES, "t6_msg0");
        serve_msg(4, ONES, "t6_msg1");
        wait_done(20, "t6_done");
        repeat (3) tick();

        chk("req_queue_left", 64'(exp_req.size()), 64'd0);
        chk("res_queue_left", 64'(exp_res.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
